// File: rtl/pipeline_stall_controller_if.sv
// Pipeline-to-stall-controller bundle: hazard/branch/jump/memory status in,
// per-stage freeze/flush/bubble controls and performance counters out.
interface pipeline_stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic             hazard_detected;
    logic             br_taken;
    logic             is_jmp;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_freeze;
    logic             if_id_freeze;
    logic             if_id_flush;
    logic             id_exe_bubble;
    logic             back_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline datapath side
    modport master (
        output hazard_detected, br_taken, is_jmp, mem_req, mem_ready,
        input  pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
               back_freeze, mem_timeout, stall_cnt, flush_cnt
    );

    // Stall controller side
    modport slave (
        input  hazard_detected, br_taken, is_jmp, mem_req, mem_ready,
        output pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
               back_freeze, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: Mealy freeze/flush
// controls, memory wait FSM with timeout watchdog, saturating perf counters.
module pipeline_stall_controller #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_controller_if.slave ctl
);
    localparam int unsigned WAIT_W = 16;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic mem_stall_c;
    logic pc_freeze_c;
    logic if_id_flush_c;
    logic id_exe_bubble_c;

    // Zero-latency controls; a memory stall masks every flush and bubble
    always_comb begin
        mem_stall_c     = (ctl.mem_req & ~ctl.mem_ready) | (state == ST_ERROR);
        pc_freeze_c     = mem_stall_c | (ctl.hazard_detected & ~ctl.br_taken);
        id_exe_bubble_c = ~mem_stall_c & (ctl.br_taken | ctl.hazard_detected);
        if_id_flush_c   = ~mem_stall_c &
                          (ctl.br_taken | (ctl.is_jmp & ~ctl.hazard_detected));
    end

    assign ctl.pc_freeze     = pc_freeze_c;
    assign ctl.if_id_freeze  = pc_freeze_c;
    assign ctl.if_id_flush   = if_id_flush_c;
    assign ctl.id_exe_bubble = id_exe_bubble_c;
    assign ctl.back_freeze   = mem_stall_c;
    assign ctl.mem_timeout   = timeout_q;
    assign ctl.stall_cnt     = stall_cnt_q;
    assign ctl.flush_cnt     = flush_cnt_q;

    // Memory wait FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            timeout_q <= (state_nxt == ST_ERROR);
        end
    end

    // Next state: ready wins over withdrawal, withdrawal wins over timeout
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (ctl.mem_req && !ctl.mem_ready) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (ctl.mem_ready || !ctl.mem_req) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt = ST_ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_freeze_c && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (if_id_flush_c && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: vector table, directed corner sequences
// and randomized traffic against a priority-rule reference model.
module tb_pipeline_stall_controller;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 6;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: consecutive stalled cycles of the current access
    int m_stalled;
    bit m_err;
    int m_stall_cnt;
    int m_flush_cnt;

    typedef struct {
        bit hz, br, jmp, req, rdy;
        bit pf, fl, bb, bf;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stalled   = 0;
        m_err       = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Expected controls from the priority list: mem stall > branch > hazard > jump
    task automatic model_out(output bit pf, output bit fl, output bit bb, output bit bf);
        bit ms;
        ms = m_err || (bus.mem_req && !bus.mem_ready);
        {pf, fl, bb, bf} = 4'b0000;
        if (ms)                       {pf, fl, bb, bf} = 4'b1001;
        else if (bus.br_taken)        {pf, fl, bb, bf} = 4'b0110;
        else if (bus.hazard_detected) {pf, fl, bb, bf} = 4'b1010;
        else if (bus.is_jmp)          {pf, fl, bb, bf} = 4'b0100;
    endtask

    task automatic apply(input bit hz, input bit br, input bit jmp, input bit req, input bit rdy);
        @(negedge clk);
        bus.hazard_detected = hz;
        bus.br_taken        = br;
        bus.is_jmp          = jmp;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
        #1;
    endtask

    task automatic verify_model();
        bit pf, fl, bb, bf;
        model_out(pf, fl, bb, bf);
        chk("pc_freeze",     int'(bus.pc_freeze),     int'(pf));
        chk("if_id_freeze",  int'(bus.if_id_freeze),  int'(pf));
        chk("if_id_flush",   int'(bus.if_id_flush),   int'(fl));
        chk("id_exe_bubble", int'(bus.id_exe_bubble), int'(bb));
        chk("back_freeze",   int'(bus.back_freeze),   int'(bf));
        chk("mem_timeout",   int'(bus.mem_timeout),   int'(m_err));
        chk("stall_cnt",     int'(bus.stall_cnt),     m_stall_cnt);
        chk("flush_cnt",     int'(bus.flush_cnt),     m_flush_cnt);
    endtask

    task automatic advance();
        bit pf, fl, bb, bf;
        model_out(pf, fl, bb, bf);
        @(posedge clk);
        if (pf && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (fl && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        if (!m_err) begin
            if (bus.mem_req && !bus.mem_ready) begin
                m_stalled++;
                if (m_stalled > int'(TIMEOUT)) m_err = 1'b1;
            end else begin
                m_stalled = 0;
            end
        end
        #2;
    endtask

    task automatic cyc(input bit hz, input bit br, input bit jmp, input bit req, input bit rdy);
        apply(hz, br, jmp, req, rdy);
        verify_model();
    endtask

    task automatic step(input bit hz, input bit br, input bit jmp, input bit req, input bit rdy);
        cyc(hz, br, jmp, req, rdy);
        advance();
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        model_reset();
        verify_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.hazard_detected = 1'b0;
        bus.br_taken        = 1'b0;
        bus.is_jmp          = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
        model_reset();

        //              hz br jmp req rdy  pf fl bb bf
        tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0,  1, 0, 1, 0};
        tbl[2]  = '{0, 1, 0, 0, 0,  0, 1, 1, 0};
        tbl[3]  = '{0, 0, 1, 0, 0,  0, 1, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0,  0, 1, 1, 0};
        tbl[5]  = '{1, 0, 1, 0, 0,  1, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, 0, 0,  0, 1, 1, 0};
        tbl[7]  = '{1, 1, 1, 0, 0,  0, 1, 1, 0};
        tbl[8]  = '{0, 1, 0, 1, 1,  0, 1, 1, 0};
        tbl[9]  = '{1, 1, 0, 1, 0,  1, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 0,  0, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0,  1, 0, 0, 1};
        tbl[12] = '{1, 0, 0, 1, 1,  1, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0,  0, 0, 0, 0};

        // Reset release then idle
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        chk("idle_stall_cnt", int'(bus.stall_cnt), 0);
        chk("idle_flush_cnt", int'(bus.flush_cnt), 0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].hz, tbl[i].br, tbl[i].jmp, tbl[i].req, tbl[i].rdy);
            chk($sformatf("tbl%0d_pf", i), int'(bus.pc_freeze),     int'(tbl[i].pf));
            chk($sformatf("tbl%0d_fl", i), int'(bus.if_id_flush),   int'(tbl[i].fl));
            chk($sformatf("tbl%0d_bb", i), int'(bus.id_exe_bubble), int'(tbl[i].bb));
            chk($sformatf("tbl%0d_bf", i), int'(bus.back_freeze),   int'(tbl[i].bf));
            verify_model();
            advance();
        end

        // Single-cycle load-use hazard
        do_reset();
        cyc(1, 0, 0, 0, 0);
        chk("hz_pc_freeze", int'(bus.pc_freeze), 1);
        chk("hz_if_id_freeze", int'(bus.if_id_freeze), 1);
        chk("hz_bubble", int'(bus.id_exe_bubble), 1);
        chk("hz_flush", int'(bus.if_id_flush), 0);
        advance();
        chk("hz_stall_cnt", int'(bus.stall_cnt), 1);

        // Hazard with taken branch: branch squashes, no freeze
        do_reset();
        cyc(1, 1, 0, 0, 0);
        chk("hzbr_pc_freeze", int'(bus.pc_freeze), 0);
        chk("hzbr_flush", int'(bus.if_id_flush), 1);
        chk("hzbr_bubble", int'(bus.id_exe_bubble), 1);
        advance();
        chk("hzbr_flush_cnt", int'(bus.flush_cnt), 1);
        chk("hzbr_stall_cnt", int'(bus.stall_cnt), 0);

        // Jump held behind a two-cycle hazard
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc((i < 2) ? 1'b1 : 1'b0, 0, 1, 0, 0);
            chk($sformatf("jmp_flush_c%0d", i), int'(bus.if_id_flush), (i < 2) ? 0 : 1);
            advance();
        end

        // Multi-cycle memory access with a taken branch waiting in EXE
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1, (i == 3) ? 1'b1 : 1'b0);
            chk($sformatf("mw_back_freeze_c%0d", i + 1), int'(bus.back_freeze), (i < 3) ? 1 : 0);
            chk($sformatf("mw_flush_c%0d", i + 1), int'(bus.if_id_flush), (i < 3) ? 0 : 1);
            advance();
        end
        chk("mw_stall_cnt", int'(bus.stall_cnt), 3);
        step(0, 0, 0, 1, 0);
        chk("mw_back_in_run", int'(bus.back_freeze), 1);
        step(0, 0, 0, 0, 0);

        // Watchdog timeout, late ready ignored, async reset out of ERROR
        do_reset();
        for (int i = 0; i < int'(TIMEOUT) + 1; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk($sformatf("to_pending_c%0d", i), int'(bus.mem_timeout), 0);
            advance();
        end
        chk("to_mem_timeout", int'(bus.mem_timeout), 1);
        cyc(0, 0, 0, 1, 1);
        chk("to_ready_ignored", int'(bus.back_freeze), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("to_async_timeout", int'(bus.mem_timeout), 0);
        chk("to_async_back_freeze", int'(bus.back_freeze), 0);
        chk("to_async_stall_cnt", int'(bus.stall_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Counter saturation
        do_reset();
        for (int i = 0; i < CNT_MAX + 8; i++) step(1, 0, 0, 0, 0);
        chk("sat_stall_cnt", int'(bus.stall_cnt), CNT_MAX);
        for (int i = 0; i < CNT_MAX + 8; i++) step(0, 0, 1, 0, 0);
        chk("sat_flush_cnt", int'(bus.flush_cnt), CNT_MAX);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 199) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0,
                 $urandom_range(0, 1) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
